multiexp_fp2_feeder: RTL and testbench
======================================

// Module: multiexp_fp2_feeder
// PURPOSE
// Upstream stage of the Fp2 multiexp core. Accepts one load of NUM_IN scalar/G2-point pairs
// (7 FE words per pair, scalar first) into on-chip RAM. Replays them as the looping stream the
// core consumes: KEY_BITS passes of pairs 0..NUM_IN-1. This frees the host after a single
// transfer. ctl[0]==1 (single-add collapse mode) is passed straight through without buffering.
// PARAMETERS
// DAT_BITS  381   width of one FE word ($bits(FE_TYPE))
// CTL_BITS  16    ctl field width; must match the core's CTL_BITS
// KEY_BITS  256   scalar bits = number of replay passes
// MAX_IN    1024  max pairs stored; RAM depth = 7*MAX_IN words
// PORTS
// i_clk      in   1         clock
// i_rst_n    in   1         asynchronous active-low reset
// i_load_if  sink  if_axi_stream DAT_BITS/CTL_BITS  host pairs; sop=word0, eop=word6 of each pair
// o_pnt_scl_if source if_axi_stream DAT_BITS/CTL_BITS  to core i_pnt_scl_if; same framing
// i_num_in   in   64        pair count, sampled when the first load word is accepted in IDLE
// o_busy     out  1         high in any state other than IDLE
// o_err      out  1         one-cycle pulse on a rejected load
// o_stall_cnt out 32        stall statistics (see CONFIGURATION)
// BEHAVIOUR
// Reset (async assert, sync deassert on i_clk)
// - state=IDLE; all counters 0
// - o_pnt_scl_if.val=0, i_load_if.rdy=0, o_busy=0, o_err=0, o_stall_cnt=0
// States: IDLE, LOAD, PLAY, BYPASS, DISCARD
// - IDLE: i_load_if.rdy=1. On the first accepted word, latch num_in=i_num_in and ctl=i_load_if.ctl.
//   - ctl[0]==1: go to BYPASS; this word is forwarded.
//   - num_in==0 or num_in>MAX_IN: pulse o_err; go to DISCARD (0: return to IDLE next cycle).
//   - otherwise: write the word at addr 0; go to LOAD.
// - LOAD: i_load_if.rdy=1. Each accepted word is written to the next address.
//   - After word 7*num_in-1 is written: go to PLAY the next cycle.
//   - Host sop/eop are not checked; the word count alone defines pair boundaries.
// - PLAY: 1-cycle sync RAM read plus an output register with a 2-entry skid buffer.
//   - Full throughput: one word per cycle while o_pnt_scl_if.rdy=1.
//   - First word valid exactly 2 cycles after the last LOAD write.
//   - Counters: word_cnt 0..6, pair_cnt 0..num_in-1, pass_cnt 0..KEY_BITS-1.
//   - Each counter wraps when it reaches its limit, in that order.
//   - sop=(word_cnt==0), eop=(word_cnt==6); ctl = latched ctl on every word.
//   - The final word leaves on pass KEY_BITS-1, pair num_in-1, word 6.
//   - Go to IDLE the cycle after that word is accepted (val&&rdy). i_load_if.rdy stays 0 in PLAY.
// - BYPASS: o_pnt_scl_if mirrors i_load_if through one register stage (dat/sop/eop/ctl).
//   - i_load_if.rdy = ~o.val | o.rdy.
//   - Leave BYPASS after 7*num_in words are forwarded.
// - DISCARD: rdy=1; drop 7*num_in words, then go to IDLE. Nothing is output.
// Handshake rules
// - o.val is never deasserted and o.dat never changes while o.val&&~o.rdy.
// - A word transfers only on val&&rdy.
// Arithmetic
// - Addresses: $clog2(7*MAX_IN) bits.
// - Word limit 7*num_in is computed once at latch time in a 64-bit field.
// - The MAX_IN check runs before any multiply is used.
// Boundaries
// - num_in==1: each pass is 7 words.
// - Continuous rdy=0 in PLAY: output holds and no counter advances.
// - The core deasserting rdy on the cycle eop is presented: eop stays held.
// - i_num_in changes outside IDLE: ignored.
// - Reset in LOAD/PLAY: the stream aborts at once; RAM contents are don't-care.
// CONFIGURATION
// MULTIEXP_FEEDER_STATS_EN defined:
// - o_stall_cnt increments (saturating at 2^32-1) each cycle o.val&&~o.rdy in PLAY or BYPASS.
// - It clears on entry to LOAD or BYPASS.
// Not defined: o_stall_cnt is tied to 0 and no counter logic is built.
// TESTING
// - Load num_in=3, KEY_BITS=4, words=index -> 84 output words, pattern 0..20 repeated 4x,
//   sop/eop every 7 words, busy falls after final eop.
// - Same load with random o.rdy (50%) -> identical word sequence, no drop or duplicate,
//   dat stable while stalled.
// - ctl[0]=1, num_in=1, 7 words -> the 7 words forwarded once with the same ctl; no replay; back to IDLE.
// - num_in=MAX_IN+1 -> o_err pulse, 7*(MAX_IN+1) words accepted and dropped, o.val never high.
// - Assert i_rst_n=0 mid-PLAY (pass 2) -> o.val=0 asynchronously;
//   a new load of num_in=2 then replays correctly.
// - STATS_EN: hold rdy=0 for 10 cycles with val high -> o_stall_cnt=10;
//   without the macro o_stall_cnt=0.

Source files
------------

// File: rtl/multiexp_fp2_feeder.sv
`default_nettype none
// ============================================================================
// Module   : multiexp_fp2_feeder
// Purpose  : Buffers one load of scalar/G2-point pairs and replays it KEY_BITS
//            times as the looping stream of the Fp2 multiexp core.
// Options  : MULTIEXP_FEEDER_STATS_EN builds the output stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module multiexp_fp2_feeder #(
  parameter int DAT_BITS = 381,
  parameter int CTL_BITS = 16,
  parameter int KEY_BITS = 256,
  parameter int MAX_IN   = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  // host load stream
  input  logic [DAT_BITS-1:0] i_load_dat,
  input  logic                i_load_val,
  input  logic                i_load_sop,
  input  logic                i_load_eop,
  input  logic [CTL_BITS-1:0] i_load_ctl,
  output logic                o_load_rdy,
  // stream to the core
  output logic [DAT_BITS-1:0] o_pnt_scl_dat,
  output logic                o_pnt_scl_val,
  output logic                o_pnt_scl_sop,
  output logic                o_pnt_scl_eop,
  output logic [CTL_BITS-1:0] o_pnt_scl_ctl,
  input  logic                i_pnt_scl_rdy,
  // control / status
  input  logic [63:0]         i_num_in,
  output logic                o_busy,
  output logic                o_err,
  output logic [31:0]         o_stall_cnt
);

  localparam int C_DEPTH = 7 * MAX_IN;
  localparam int C_AW    = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
  localparam int C_PW    = $clog2(MAX_IN + 1);
  localparam int C_KW    = $clog2(KEY_BITS + 1);
  localparam logic [C_KW-1:0] C_PASS_LAST = C_KW'(KEY_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PLAY    = 3'd2,
    S_BYPASS  = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  typedef struct packed {
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic                sop;
    logic                eop;
    logic                last;
  } ent_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_run;
  logic [CTL_BITS-1:0] r_ctl;
  logic [63:0]         r_limit;
  logic [63:0]         r_cnt;
  logic [C_PW-1:0]     r_num_m1;
  logic                r_err;

  logic                w_acc;
  logic                w_pop;
  logic                w_bad;
  logic                w_first;
  logic                w_wr_en;
  logic [C_AW-1:0]     w_wr_addr;

  logic [DAT_BITS-1:0] r_mem [C_DEPTH];
  logic [DAT_BITS-1:0] r_rd_dat;
  logic                r_rd_val;
  logic                r_rd_sop;
  logic                r_rd_eop;
  logic                r_rd_last;
  logic [C_AW-1:0]     r_rd_addr;
  logic [2:0]          r_word;
  logic [C_PW-1:0]     r_pair;
  logic [C_KW-1:0]     r_pass;
  logic                r_issue_done;
  logic                w_issue;
  logic                w_last_issue;
  logic [2:0]          w_occ;

  ent_t                r_q0;
  ent_t                r_q1;
  ent_t                w_in;
  logic [1:0]          r_fcnt;
  logic                w_push;

  assign w_pop   = o_pnt_scl_val && i_pnt_scl_rdy;
  assign w_acc   = i_load_val && o_load_rdy;
  assign w_first = (r_state == S_IDLE) && w_acc;
  assign w_bad   = (i_num_in == 64'd0) || (i_num_in > 64'(MAX_IN));

  // --------------------------------------------------------------------------
  // Load-side ready
  // --------------------------------------------------------------------------
  always_comb begin
    o_load_rdy = 1'b0;
    case (r_state)
      S_IDLE:    o_load_rdy = r_run;
      S_LOAD:    o_load_rdy = 1'b1;
      S_DISCARD: o_load_rdy = (r_cnt < r_limit);
      S_BYPASS:  o_load_rdy = (r_cnt < r_limit) && ((r_fcnt == 2'd0) || w_pop);
      default:   o_load_rdy = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (i_load_ctl[0]) begin
            w_next = S_BYPASS;
          end else if (w_bad) begin
            w_next = S_DISCARD;
          end else begin
            w_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_acc && (r_cnt == r_limit - 64'd1)) begin
          w_next = S_PLAY;
        end
      end
      S_PLAY: begin
        if (w_pop && r_q0.last) begin
          w_next = S_IDLE;
        end
      end
      S_BYPASS: begin
        // all words accepted and the output register drained
        if ((r_cnt >= r_limit) && ((r_fcnt == 2'd0) || w_pop)) begin
          w_next = S_IDLE;
        end
      end
      S_DISCARD: begin
        if ((r_cnt >= r_limit) || (w_acc && (r_cnt + 64'd1 >= r_limit))) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Load bookkeeping: latched parameters and accepted-word counter
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run    <= 1'b0;
      r_err    <= 1'b0;
      r_ctl    <= '0;
      r_limit  <= 64'd0;
      r_cnt    <= 64'd0;
      r_num_m1 <= '0;
    end else begin
      r_run <= 1'b1;
      r_err <= w_first && !i_load_ctl[0] && w_bad;
      if (w_first) begin
        r_ctl    <= i_load_ctl;
        r_cnt    <= 64'd1;
        r_num_m1 <= C_PW'(i_num_in - 64'd1);
        r_limit  <= i_num_in * 64'd7;
      end else if (w_acc) begin
        r_cnt <= r_cnt + 64'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pair RAM (single write port, registered read port)
  // --------------------------------------------------------------------------
  assign w_wr_en   = w_acc && ((w_first && !i_load_ctl[0] && !w_bad) || (r_state == S_LOAD));
  assign w_wr_addr = w_first ? '0 : r_cnt[C_AW-1:0];

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= i_load_dat;
    end
    if (w_issue) begin
      r_rd_dat <= r_mem[r_rd_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Replay sequencer: a read is issued only if the skid buffer can still hold
  // it once it leaves the RAM stage.
  // --------------------------------------------------------------------------
  assign w_occ        = {1'b0, r_fcnt} + {2'b00, r_rd_val} - {2'b00, w_pop};
  assign w_issue      = (r_state == S_PLAY) && !r_issue_done && (w_occ < 3'd2);
  assign w_last_issue = (r_word == 3'd6) && (r_pair == r_num_m1) && (r_pass == C_PASS_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_val     <= 1'b0;
      r_rd_sop     <= 1'b0;
      r_rd_eop     <= 1'b0;
      r_rd_last    <= 1'b0;
      r_rd_addr    <= '0;
      r_word       <= 3'd0;
      r_pair       <= '0;
      r_pass       <= '0;
      r_issue_done <= 1'b0;
    end else begin
      r_rd_val <= w_issue;
      if (w_issue) begin
        r_rd_sop  <= (r_word == 3'd0);
        r_rd_eop  <= (r_word == 3'd6);
        r_rd_last <= w_last_issue;
      end
      if (r_state != S_PLAY) begin
        r_rd_addr    <= '0;
        r_word       <= 3'd0;
        r_pair       <= '0;
        r_pass       <= '0;
        r_issue_done <= 1'b0;
      end else if (w_issue) begin
        if (r_word == 3'd6) begin
          r_word <= 3'd0;
          if (r_pair == r_num_m1) begin
            r_pair    <= '0;
            r_rd_addr <= '0;
            if (r_pass == C_PASS_LAST) begin
              r_pass       <= '0;
              r_issue_done <= 1'b1;
            end else begin
              r_pass <= r_pass + 1'b1;
            end
          end else begin
            r_pair    <= r_pair + 1'b1;
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end else begin
          r_word    <= r_word + 3'd1;
          r_rd_addr <= r_rd_addr + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output skid buffer; r_q0 is the output register. Bypass words share it
  // and never occupy more than the head entry.
  // --------------------------------------------------------------------------
  assign w_push = r_rd_val ||
                  (w_acc && ((w_first && i_load_ctl[0]) || (r_state == S_BYPASS)));

  always_comb begin
    if (r_rd_val) begin
      w_in.dat  = r_rd_dat;
      w_in.ctl  = r_ctl;
      w_in.sop  = r_rd_sop;
      w_in.eop  = r_rd_eop;
      w_in.last = r_rd_last;
    end else begin
      w_in.dat  = i_load_dat;
      w_in.ctl  = i_load_ctl;
      w_in.sop  = i_load_sop;
      w_in.eop  = i_load_eop;
      w_in.last = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q0   <= '0;
      r_q1   <= '0;
      r_fcnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_fcnt == 2'd0) begin
            r_q0 <= w_in;
          end else begin
            r_q1 <= w_in;
          end
          r_fcnt <= r_fcnt + 2'd1;
        end
        2'b01: begin
          r_q0   <= r_q1;
          r_fcnt <= r_fcnt - 2'd1;
        end
        2'b11: begin
          if (r_fcnt == 2'd1) begin
            r_q0 <= w_in;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= w_in;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_pnt_scl_val = (r_fcnt != 2'd0);
  assign o_pnt_scl_dat = r_q0.dat;
  assign o_pnt_scl_sop = r_q0.sop;
  assign o_pnt_scl_eop = r_q0.eop;
  assign o_pnt_scl_ctl = r_q0.ctl;
  assign o_busy        = (r_state != S_IDLE);
  assign o_err         = r_err;

  // --------------------------------------------------------------------------
  // Stall statistics
  // --------------------------------------------------------------------------
`ifdef MULTIEXP_FEEDER_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= 32'd0;
    end else if ((r_state == S_IDLE) && ((w_next == S_LOAD) || (w_next == S_BYPASS))) begin
      r_stall_cnt <= 32'd0;
    end else if (((r_state == S_PLAY) || (r_state == S_BYPASS)) &&
                 o_pnt_scl_val && !i_pnt_scl_rdy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multiexp_fp2_feeder.sv
`default_nettype none
// Scoreboard bench for multiexp_fp2_feeder: expected words are queued at
// stimulus time and a monitor compares every transfer on the core-side port.
module tb_multiexp_fp2_feeder;
  localparam int DAT_BITS = 381;
  localparam int CTL_BITS = 16;
  localparam int KEY_BITS = 4;
  localparam int MAX_IN   = 4;
`ifdef MULTIEXP_FEEDER_STATS_EN
  localparam logic [31:0] EXP_STALL = 32'd10;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  typedef struct packed {
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic                sop;
    logic                eop;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DAT_BITS-1:0] load_dat = '0;
  logic                load_val = 1'b0;
  logic                load_sop = 1'b0;
  logic                load_eop = 1'b0;
  logic [CTL_BITS-1:0] load_ctl = '0;
  logic                load_rdy;
  logic [DAT_BITS-1:0] out_dat;
  logic                out_val;
  logic                out_sop;
  logic                out_eop;
  logic [CTL_BITS-1:0] out_ctl;
  logic                out_rdy = 1'b1;
  logic [63:0]         num_in = 64'd0;
  logic                busy;
  logic                err;
  logic [31:0]         stall_cnt;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  int   err_pulses = 0;
  int   rdy_mode = 0;

  multiexp_fp2_feeder #(
    .DAT_BITS(DAT_BITS), .CTL_BITS(CTL_BITS), .KEY_BITS(KEY_BITS), .MAX_IN(MAX_IN)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_load_dat(load_dat), .i_load_val(load_val), .i_load_sop(load_sop),
    .i_load_eop(load_eop), .i_load_ctl(load_ctl), .o_load_rdy(load_rdy),
    .o_pnt_scl_dat(out_dat), .o_pnt_scl_val(out_val), .o_pnt_scl_sop(out_sop),
    .o_pnt_scl_eop(out_eop), .o_pnt_scl_ctl(out_ctl), .i_pnt_scl_rdy(out_rdy),
    .i_num_in(num_in), .o_busy(busy), .o_err(err), .o_stall_cnt(stall_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [DAT_BITS-1:0] act,
                       input logic [DAT_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // core-side ready pattern: 0 = always ready, 1 = random, 2 = held low
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = 1'($urandom_range(0, 1));
      default: out_rdy = 1'b0;
    endcase
  end

  // monitor: compares each transfer and checks hold-while-stalled
  initial begin
    logic                held_v;
    logic [DAT_BITS-1:0] held_dat;
    exp_t                e;
    held_v = 1'b0;
    held_dat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        if (err) err_pulses++;
        if (held_v) begin
          check("val_held", DAT_BITS'(out_val), DAT_BITS'(1));
          check("dat_held", out_dat, held_dat);
        end
        if (out_val && out_rdy) begin
          if (sb_q.size() == 0) begin
            check("unexpected_word", DAT_BITS'(sb_q.size()), DAT_BITS'(1));
          end else begin
            e = sb_q.pop_front();
            check("out_dat", out_dat, e.dat);
            check("out_ctl_sop_eop", DAT_BITS'({out_ctl, out_sop, out_eop}),
                  DAT_BITS'({e.ctl, e.sop, e.eop}));
          end
          pops++;
          held_v = 1'b0;
        end else if (out_val) begin
          held_v = 1'b1;
          held_dat = out_dat;
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  task automatic push_replay(input int num, input int base, input logic [CTL_BITS-1:0] ctl);
    exp_t e;
    for (int p = 0; p < KEY_BITS; p++) begin
      for (int w = 0; w < 7 * num; w++) begin
        e.dat = DAT_BITS'(base + w);
        e.ctl = ctl;
        e.sop = ((w % 7) == 0);
        e.eop = ((w % 7) == 6);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic push_bypass(input int nwords, input int base, input logic [CTL_BITS-1:0] ctl);
    exp_t e;
    for (int w = 0; w < nwords; w++) begin
      e.dat = DAT_BITS'(base + w);
      e.ctl = ctl;
      e.sop = ((w % 7) == 0);
      e.eop = ((w % 7) == 6);
      sb_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [DAT_BITS-1:0] dat, input logic [CTL_BITS-1:0] ctl,
                           input logic sop, input logic eop);
    logic acc;
    int   n;
    load_dat = dat;
    load_ctl = ctl;
    load_sop = sop;
    load_eop = eop;
    load_val = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = load_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("load_accept_timeout", DAT_BITS'(0), DAT_BITS'(1));
  endtask

  task automatic send_load(input logic [63:0] num, input logic [CTL_BITS-1:0] ctl,
                           input int nwords, input int base);
    num_in = num;
    for (int i = 0; i < nwords; i++) begin
      send_word(DAT_BITS'(base + i), ctl, (i % 7) == 0, (i % 7) == 6);
      if (i == 0) num_in = 64'h0000_0000_DEAD_0002;
    end
    load_val = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (k < bound && (busy || sb_q.size() != 0)) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("idle_busy", DAT_BITS'(busy), DAT_BITS'(0));
    check("idle_queue_empty", DAT_BITS'(sb_q.size()), DAT_BITS'(0));
  endtask

  initial begin
    int p0;
    int e0;
    int k;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_load_rdy", DAT_BITS'(load_rdy), DAT_BITS'(0));
    check("rst_val", DAT_BITS'(out_val), DAT_BITS'(0));
    check("rst_busy", DAT_BITS'(busy), DAT_BITS'(0));
    check("rst_err", DAT_BITS'(err), DAT_BITS'(0));
    check("rst_stall", DAT_BITS'(stall_cnt), DAT_BITS'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_load_rdy", DAT_BITS'(load_rdy), DAT_BITS'(1));

    // 3 pairs, 4 passes, full throughput
    p0 = pops;
    push_replay(3, 0, 16'h0010);
    send_load(64'd3, 16'h0010, 21, 0);
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (out_val) break;
      @(posedge clk);
      k++;
    end
    check("first_valid_latency", DAT_BITS'(k), DAT_BITS'(2));
    check("busy_in_play", DAT_BITS'(busy), DAT_BITS'(1));
    check("play_load_rdy", DAT_BITS'(load_rdy), DAT_BITS'(0));
    wait_idle(400);
    check("replay_word_count", DAT_BITS'(pops - p0), DAT_BITS'(84));

    // same load with random back-pressure
    rdy_mode = 1;
    p0 = pops;
    push_replay(3, 100, 16'h0020);
    send_load(64'd3, 16'h0020, 21, 100);
    wait_idle(3000);
    rdy_mode = 0;
    check("random_rdy_word_count", DAT_BITS'(pops - p0), DAT_BITS'(84));

    // bypass: forwarded once, no replay
    p0 = pops;
    e0 = err_pulses;
    push_bypass(7, 200, 16'h0A01);
    send_load(64'd1, 16'h0A01, 7, 200);
    wait_idle(200);
    check("bypass_word_count", DAT_BITS'(pops - p0), DAT_BITS'(7));
    check("bypass_no_err", DAT_BITS'(err_pulses - e0), DAT_BITS'(0));

    // oversize load is rejected and drained
    p0 = pops;
    e0 = err_pulses;
    send_load(64'(MAX_IN + 1), 16'h0030, 7 * (MAX_IN + 1), 300);
    wait_idle(100);
    check("discard_err_pulse", DAT_BITS'(err_pulses - e0), DAT_BITS'(1));
    check("discard_no_output", DAT_BITS'(pops - p0), DAT_BITS'(0));

    // stall statistics with ready held low
    rdy_mode = 2;
    p0 = pops;
    push_replay(1, 400, 16'h0040);
    send_load(64'd1, 16'h0040, 7, 400);
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (out_val) break;
      @(posedge clk);
      k++;
    end
    check("stall_val_seen", DAT_BITS'(out_val), DAT_BITS'(1));
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("stall_cnt", DAT_BITS'(stall_cnt), DAT_BITS'(EXP_STALL));
    check("stall_no_advance", DAT_BITS'(pops - p0), DAT_BITS'(0));
    @(posedge clk);
    #1;
    rdy_mode = 0;
    wait_idle(200);
    check("stall_word_count", DAT_BITS'(pops - p0), DAT_BITS'(28));

    // reset during pass 2, then a fresh load
    p0 = pops;
    push_replay(2, 500, 16'h0050);
    send_load(64'd2, 16'h0050, 14, 500);
    k = 0;
    while (k < 400 && (pops - p0) < 31) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("reached_pass2", DAT_BITS'((pops - p0) >= 31), DAT_BITS'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_val", DAT_BITS'(out_val), DAT_BITS'(0));
    check("async_rst_busy", DAT_BITS'(busy), DAT_BITS'(0));
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    p0 = pops;
    push_replay(2, 600, 16'h0060);
    send_load(64'd2, 16'h0060, 14, 600);
    wait_idle(600);
    check("post_rst_word_count", DAT_BITS'(pops - p0), DAT_BITS'(56));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
